// File: rtl/oam_dma_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_arbiter_if
// Purpose  : CPU-side, system-bus and OAM signal bundle for oam_dma_arbiter.
//            The "slave" modport is the arbiter's view; "master" is the view
//            of whatever surrounds it (core, bus fabric, OAM).
// Revision : 1.0 - initial release
// ============================================================================
interface oam_dma_arbiter_if;
    // Core side
    logic [15:0] CPU_A;
    logic [7:0]  CPU_DO;
    logic        CPU_RD;
    logic        CPU_WR;
    logic [7:0]  CPU_DI;
    // System bus side
    logic [15:0] BUS_A;
    logic [7:0]  BUS_DO;
    logic        BUS_RD;
    logic        BUS_WR;
    logic [7:0]  BUS_DI;
    // OAM write port and status
    logic [7:0]  OAM_A;
    logic [7:0]  OAM_D;
    logic        OAM_WR;
    logic        DMA_ACTIVE;

    modport slave (
        input  CPU_A, CPU_DO, CPU_RD, CPU_WR, BUS_DI,
        output CPU_DI, BUS_A, BUS_DO, BUS_RD, BUS_WR,
        output OAM_A, OAM_D, OAM_WR, DMA_ACTIVE
    );

    modport master (
        output CPU_A, CPU_DO, CPU_RD, CPU_WR, BUS_DI,
        input  CPU_DI, BUS_A, BUS_DO, BUS_RD, BUS_WR,
        input  OAM_A, OAM_D, OAM_WR, DMA_ACTIVE
    );
endinterface
`default_nettype wire

// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_arbiter
// Purpose  : Sprite-attribute DMA engine and core/system-bus arbiter. A core
//            write to the trigger register copies DMA_LEN bytes from page
//            src:00.. into OAM, one byte per M-cycle, while gating core
//            accesses outside FFxx.
// Options  : OAM_DMA_CONFLICT_EN - when defined, a blocked core read during
//            the copy returns the byte the DMA is fetching that M-cycle
//            instead of 8'hFF.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_arbiter #(
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  wire logic CLK,
    input  wire logic nRESET,
    input  wire logic MCYC,
    oam_dma_arbiter_if.slave dma_if
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [7:0] C_LAST_IDX = 8'(DMA_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] idx_q, idx_d;

    logic       w_reg_hit;
    logic       w_reg_wr;
    logic       w_cpu_grant;
    logic       w_dma_own;
    logic [7:0] w_src_fold;
    logic [7:0] w_blocked_rd;

    // The trigger register is serviced internally, so touching it never
    // steals the DMA slot; every other FFxx access wins the bus.
    assign w_reg_hit   = (dma_if.CPU_A == DMA_REG_ADDR);
    assign w_reg_wr    = dma_if.CPU_WR && w_reg_hit;
    assign w_cpu_grant = (dma_if.CPU_A[15:8] == 8'hFF) && !w_reg_hit;
    assign w_dma_own   = (state_q != ST_IDLE) && !w_cpu_grant;

    // E0..FF are echo RAM: fold onto C0..DF by clearing bit 5.
    assign w_src_fold  = (dma_if.CPU_DO >= 8'hE0) ? (dma_if.CPU_DO & 8'hDF)
                                                  : dma_if.CPU_DO;

`ifdef OAM_DMA_CONFLICT_EN
    assign w_blocked_rd = (state_q == ST_RUN) ? dma_if.BUS_DI : 8'hFF;
`else
    assign w_blocked_rd = 8'hFF;
`endif

    // State register: everything advances only on M-cycle boundaries (via _d).
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            src_q   <= 8'h00;
            idx_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: a trigger write restarts from any state; RUN walks idx
    // unless the core holds the bus; START always lasts one M-cycle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        if (MCYC) begin
            if (w_reg_wr) begin
                src_d   = w_src_fold;
                idx_d   = 8'h00;
                state_d = ST_START;
            end else begin
                case (state_q)
                    ST_START: state_d = ST_RUN;
                    ST_RUN: begin
                        if (!w_cpu_grant) begin
                            if (idx_q == C_LAST_IDX) begin
                                state_d = ST_IDLE;
                                idx_d   = 8'h00;
                            end else begin
                                idx_d = idx_q + 8'd1;
                            end
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Bus mux: transparent unless the DMA owns this M-cycle; register reads
    // always return the latched source page.
    always_comb begin
        dma_if.BUS_A  = dma_if.CPU_A;
        dma_if.BUS_DO = dma_if.CPU_DO;
        dma_if.BUS_RD = dma_if.CPU_RD;
        dma_if.BUS_WR = dma_if.CPU_WR;
        dma_if.CPU_DI = dma_if.BUS_DI;
        if (w_dma_own) begin
            dma_if.BUS_A  = {src_q, idx_q};
            dma_if.BUS_DO = 8'h00;
            dma_if.BUS_RD = (state_q == ST_RUN);
            dma_if.BUS_WR = 1'b0;
            dma_if.CPU_DI = w_blocked_rd;
        end
        if (w_reg_hit) begin
            dma_if.CPU_DI = src_q;
        end
    end

    // OAM write strobe is the MCYC clock of an unstalled RUN slot.
    assign dma_if.OAM_WR     = MCYC && w_dma_own && (state_q == ST_RUN);
    assign dma_if.OAM_A      = idx_q;
    assign dma_if.OAM_D      = (state_q == ST_RUN) ? dma_if.BUS_DI : 8'h00;
    assign dma_if.DMA_ACTIVE = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma_arbiter
// Purpose  : Self-checking bench for oam_dma_arbiter. A byte-array memory
//            answers the system bus; a transfer-level model (source page,
//            next byte position, active flag) predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_arbiter;

`ifdef OAM_DMA_CONFLICT_EN
    localparam bit CONFLICT = 1'b1;
`else
    localparam bit CONFLICT = 1'b0;
`endif

    logic CLK;
    logic nRESET;
    logic MCYC;

    oam_dma_arbiter_if bif ();

    oam_dma_arbiter #(
        .DMA_LEN      (160),
        .DMA_REG_ADDR (16'hFF46)
    ) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .MCYC   (MCYC),
        .dma_if (bif)
    );

    logic [7:0] mem [0:65535];
    assign bif.BUS_DI = mem[bif.BUS_A];

    int total = 0;
    int bad   = 0;
    int n_act = 0;
    int n_wr  = 0;
    logic [7:0] last_di;

    // Transfer-level model
    bit         m_active;
    logic [7:0] m_src;
    int         m_pos;   // -1: dead slot before first byte, 0..159: next byte

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One M-cycle = two CLKs, MCYC high on the second.
    task automatic step(input logic [15:0] a, input logic [7:0] d,
                        input logic rd, input logic wr);
        logic       reg_hit, ff, own, run;
        logic [7:0] p;
        logic [15:0] da;
        logic [7:0] exp_di;
        bif.CPU_A = a; bif.CPU_DO = d; bif.CPU_RD = rd; bif.CPU_WR = wr;
        MCYC = 1'b0;
        @(posedge CLK); #1; MCYC = 1'b1;
        @(negedge CLK);
        reg_hit = (a == 16'hFF46);
        ff      = (a[15:8] == 8'hFF) && !reg_hit;
        own     = m_active && !ff;
        run     = own && (m_pos >= 0);
        p       = m_pos[7:0];
        da      = {m_src, p};
        if (reg_hit)  exp_di = m_src;
        else if (own) exp_di = (CONFLICT && run) ? mem[da] : 8'hFF;
        else          exp_di = mem[a];
        if (bif.DMA_ACTIVE) n_act++;
        if (bif.OAM_WR)     n_wr++;
        last_di = bif.CPU_DI;
        chk("dma_active", 16'(bif.DMA_ACTIVE), 16'(m_active));
        chk("oam_wr", 16'(bif.OAM_WR), 16'(run));
        if (run) begin
            chk("oam_a", 16'(bif.OAM_A), 16'(p));
            chk("oam_d", 16'(bif.OAM_D), 16'(mem[da]));
            chk("bus_a_dma", bif.BUS_A, da);
        end
        if (!own) begin
            chk("bus_a_pass", bif.BUS_A, a);
            chk("bus_do_pass", 16'(bif.BUS_DO), 16'(d));
        end
        chk("bus_rd", 16'(bif.BUS_RD), 16'(own ? run : rd));
        chk("bus_wr", 16'(bif.BUS_WR), 16'(own ? 1'b0 : wr));
        if (rd) chk("cpu_di", 16'(bif.CPU_DI), 16'(exp_di));
        @(posedge CLK); #1; MCYC = 1'b0;
        if (wr && reg_hit) begin
            m_src    = (d >= 8'hE0) ? (d & 8'hDF) : d;
            m_active = 1'b1;
            m_pos    = -1;
        end else if (m_active) begin
            if (m_pos < 0) begin
                m_pos = 0;
            end else if (!ff) begin
                m_pos++;
                if (m_pos == 160) m_active = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && m_active; i++) idle(1);
        chk("drain_bound", 16'(m_active), 16'd0);
        idle(1);
    endtask

    task automatic clr();
        n_act = 0;
        n_wr  = 0;
    endtask

    initial begin
        logic [15:0] ra;
        int kind;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'hC000 + i] = 8'(i);
        mem[16'hFF80] = 8'h00;
        m_active = 1'b0; m_src = 8'h00; m_pos = 0;
        nRESET = 1'b0; MCYC = 1'b0;
        bif.CPU_A = 16'h0000; bif.CPU_DO = 8'h00; bif.CPU_RD = 1'b0; bif.CPU_WR = 1'b0;
        #23;
        // Reset state
        chk("rst_active", 16'(bif.DMA_ACTIVE), 16'd0);
        chk("rst_oam_wr", 16'(bif.OAM_WR), 16'd0);
        chk("rst_oam_a", 16'(bif.OAM_A), 16'd0);
        chk("rst_oam_d", 16'(bif.OAM_D), 16'd0);
        @(negedge CLK); nRESET = 1'b1;
        step(16'hFF46, 8'h00, 1'b1, 1'b0);
        chk("rst_src", 16'(last_di), 16'h00);

        // Idle passthrough with random traffic
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 16'hFEFF));
            step(ra, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        // Basic copy from C000
        clr();
        step(16'hFF46, 8'hC0, 1'b0, 1'b1);
        drain();
        chk("basic_active_cycles", 16'(n_act), 16'd161);
        chk("basic_oam_writes", 16'(n_wr), 16'd160);

        // Gating: granted FF80 read stalls, C123 read and 8000 write blocked
        clr();
        step(16'hFF46, 8'hC0, 1'b0, 1'b1);
        idle(10);
        step(16'hFF80, 8'h00, 1'b1, 1'b0);
        chk("gate_ff80", 16'(last_di), 16'h00);
        step(16'hC123, 8'h00, 1'b1, 1'b0);
        chk("gate_c123", 16'(last_di), 16'(CONFLICT ? 8'h09 : 8'hFF));
        step(16'h8000, 8'h5A, 1'b0, 1'b1);
        drain();
        chk("gate_active_cycles", 16'(n_act), 16'd162);
        chk("gate_oam_writes", 16'(n_wr), 16'd160);

        // Restart at idx 50 from D000
        clr();
        step(16'hFF46, 8'hC0, 1'b0, 1'b1);
        idle(51);
        step(16'hFF46, 8'hD0, 1'b0, 1'b1);
        drain();
        chk("restart_active_cycles", 16'(n_act), 16'd213);
        chk("restart_oam_writes", 16'(n_wr), 16'd211);

        // Echo fold
        step(16'hFF46, 8'hE1, 1'b0, 1'b1);
        step(16'hFF46, 8'h00, 1'b1, 1'b0);
        chk("echo_readback", 16'(last_di), 16'hC1);
        drain();

        // Asynchronous reset at idx 80
        step(16'hFF46, 8'hC0, 1'b0, 1'b1);
        idle(81);
        bif.CPU_A = 16'h0000; bif.CPU_RD = 1'b0; bif.CPU_WR = 1'b0;
        MCYC = 1'b1;
        @(negedge CLK);
        chk("pre_reset_oam_wr", 16'(bif.OAM_WR), 16'd1);
        chk("pre_reset_oam_a", 16'(bif.OAM_A), 16'd80);
        #2; nRESET = 1'b0;
        #1;
        chk("async_rst_active", 16'(bif.DMA_ACTIVE), 16'd0);
        chk("async_rst_oam_wr", 16'(bif.OAM_WR), 16'd0);
        m_active = 1'b0; m_src = 8'h00; m_pos = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("in_reset_oam_wr", 16'(bif.OAM_WR), 16'd0);
        end
        nRESET = 1'b1; MCYC = 1'b0;
        step(16'h4000, 8'h00, 1'b1, 1'b0);
        step(16'h8000, 8'h33, 1'b0, 1'b1);
        step(16'hFF46, 8'h00, 1'b1, 1'b0);

        // Trigger write on the final byte
        clr();
        step(16'hFF46, 8'hC0, 1'b0, 1'b1);
        idle(160);
        step(16'hFF46, 8'hC0, 1'b0, 1'b1);
        chk("simul_last_wr", 16'(n_wr), 16'd160);
        idle(1);
        chk("simul_start_active", 16'(bif.DMA_ACTIVE), 16'd1);
        drain();

        // Randomized traffic over a few transfers
        for (int t = 0; t < 3; t++) begin
            step(16'hFF46, 8'($urandom), 1'b0, 1'b1);
            for (int i = 0; i < 200; i++) begin
                kind = int'($urandom_range(0, 7));
                ra = 16'($urandom_range(0, 16'hFEFF));
                case (kind)
                    4: step({8'hFF, 8'($urandom)}, 8'h00, 1'b1, 1'b0);
                    5: step(ra, 8'h00, 1'b1, 1'b0);
                    6: step(ra, 8'($urandom), 1'b0, 1'b1);
                    7: if ($urandom_range(0, 15) == 0) step(16'hFF46, 8'($urandom), 1'b0, 1'b1);
                       else idle(1);
                    default: idle(1);
                endcase
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
